// File: rtl/mult_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) with valid/ready handshakes.
// One input bit is consumed per cycle; the finished value lands in a dedicated
// output register so the scratch register never shows up on bcd_out.
module mult_bcd_converter #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // The output digits must be able to hold the largest input value.
  if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_bad_digits
    $error("mult_bcd_converter: DIGITS too small for IN_W");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q;
  logic [IN_W-1:0]     bin_q;
  logic [BcdW-1:0]     scratch_q;
  logic [CntW-1:0]     cnt_q;
  logic [BcdW-1:0]     bcd_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [BcdW-1:0]      adj;
  logic [BcdW+IN_W-1:0] shifted;
  logic [BcdW-1:0]      scratch_nxt;
  logic [IN_W-1:0]      bin_nxt;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted     = {adj, bin_q} << 1;
    scratch_nxt = shifted[BcdW+IN_W-1:IN_W];
    bin_nxt     = shifted[IN_W-1:0];
  end

  // Control FSM with registered handshake outputs and the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            bin_q      <= product;
            scratch_q  <= '0;
            cnt_q      <= CntW'(IN_W);
            state_q    <= StShift;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StShift: begin
          bin_q     <= bin_nxt;
          scratch_q <= scratch_nxt;
          cnt_q     <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            bcd_q       <= scratch_nxt;
            state_q     <= StDone;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd_out   = bcd_q;

endmodule

// File: doc/mult_bcd_converter.md
# mult_bcd_converter

Downstream stage for the shift-add micro multiplier. Takes each 8-bit binary product and converts it to packed BCD (hundreds, tens, ones) with a sequential double-dabble (shift-and-add-3) engine, so the product can be shown on decimal displays. Valid/ready handshakes on both sides allow back-pressure from a display driver and ignore new products while a conversion is in flight.

## Interface
- IN_W, default 8: binary input width.
- DIGITS, default 3: BCD output digits; 10^DIGITS must exceed 2^IN_W − 1 (elaboration error otherwise).

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  product valid.
- in_ready  out  1  converter can accept a product.
- product  in  IN_W  unsigned binary product.
- out_valid  out  1  bcd_out holds a finished conversion.
- out_ready  in  1  consumer accepts bcd_out.
- bcd_out  out  4*DIGITS  packed BCD, most significant digit in top nibble.
- busy  out  1  conversion in progress (state SHIFT).

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid=1, capture product into shift register, clear BCD scratch register, load bit counter with IN_W, go to SHIFT.
- SHIFT: in_ready=0, busy=1. Each cycle: for every BCD nibble ≥5 add 3 (all nibbles in parallel, from the pre-shift value), then shift {bcd, bin} left by one; decrement counter. When counter reaches 1 (last shift this cycle), go to DONE.
- DONE: out_valid=1, bcd_out = converted value, held stable. On out_ready=1, go to IDLE. bcd_out register retains its value after leaving DONE until the next conversion's final shift.
- bcd_out driven from a dedicated output register loaded on the last SHIFT cycle; scratch register never visible on bcd_out.
- in_valid while not in IDLE: ignored, product not sampled, no state change.
- out_ready outside DONE: ignored.
- Arithmetic: add-3 per nibble is 4-bit, never carries out (nibble ≤ 9 after any valid step). Unused high digits remain 0 (e.g. hundreds nibble ≤ 2 for IN_W=8).

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, bcd_out=0, counter=0, scratch=0. Effective immediately, independent of clk.
- Reset mid-SHIFT or in DONE: conversion discarded, no out_valid; first acceptable in_valid is on the first rising edge after rst_n rises.
- Acceptance at edge k (IDLE, in_valid=1). busy=1 during cycles after edges k..k+IN_W−1. out_valid=1 after edge k+IN_W. Latency IN_W cycles (8 default).
- Output handshake at edge m (DONE, out_ready=1): out_valid=0 and in_ready=1 after edge m; next product accepted earliest at edge m+1.
- Max throughput: one conversion per IN_W+2 cycles with out_ready held high.
- in_ready, out_valid, busy are decoded from the state register only (no combinational path from in_valid/out_ready).

## Test plan
- Reset then product=0x00, in_valid pulse, out_ready=1 -> out_valid rises exactly 8 cycles after acceptance, bcd_out=0x000; in_ready back to 1 one cycle after.
- Products 255, 99, 100, 10, 9, 225 (15×15) -> bcd_out 0x255, 0x099, 0x100, 0x010, 0x009, 0x225; then exhaustive 0..255 against reference decimal model.
- Back-pressure: product=144, out_ready low for 5 cycles after out_valid -> out_valid and bcd_out=0x144 held stable all 5 cycles, clears the cycle after out_ready=1.
- Busy overlap: accept 37, then change product to 200 with in_valid=1 during SHIFT and DONE -> result 0x037, 200 not converted until in_ready=1 and in_valid still high, then 0x200.
- Reset mid-operation: accept 123, assert rst_n=0 asynchronously after 4 shift cycles (between edges) -> out_valid=0, bcd_out=0, in_ready=1 immediately; after release, 58 converts to 0x058 normally.
- Parameter variant IN_W=4, DIGITS=2: exhaustive 0..15 -> correct BCD, latency 4 cycles.
